// File: rtl/param_string_serializer.sv
// Serial stimulus source: shifts a string parameter out MSB-first, REPEAT times
// with GAP idle cycles between repetitions, then pulses done.
module param_string_serializer #(
  parameter             MSG     = "A string.",
  parameter int         MSG_LEN = 9,
  parameter logic [7:0] REPEAT  = 3,
  parameter int         GAP     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic O,
  output logic valid,
  output logic busy,
  output logic done
);
  localparam int          MW       = 8 * MSG_LEN;
  localparam int          IW       = $clog2(MW);
  localparam logic [15:0] NBITS    = 16'(MW);
  localparam logic [15:0] BIT_LAST = NBITS - 16'd1;
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  localparam logic [7:0]  REP_LAST = REPEAT - 8'd1;
  localparam logic [MW-1:0] MSG_BITS = MW'(MSG);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t      r_state, w_state_nx;
  logic [15:0] r_bitcnt, w_bitcnt_nx;
  logic [15:0] r_gapcnt, w_gapcnt_nx;
  logic [7:0]  r_repcnt, w_repcnt_nx;
  logic [IW-1:0] w_idx;
  logic        w_o_nx, w_valid_nx, w_busy_nx, w_done_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
      r_repcnt <= '0;
      O        <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_gapcnt <= w_gapcnt_nx;
      r_repcnt <= w_repcnt_nx;
      O        <= w_o_nx;
      valid    <= w_valid_nx;
      busy     <= w_busy_nx;
      done     <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_bitcnt_nx = r_bitcnt;
    w_gapcnt_nx = r_gapcnt;
    w_repcnt_nx = r_repcnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_bitcnt_nx = '0;
          w_gapcnt_nx = '0;
          w_repcnt_nx = '0;
          w_state_nx  = (REPEAT != 8'd0) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        if (r_bitcnt == BIT_LAST) begin
          if (r_repcnt == REP_LAST) begin
            w_state_nx = S_DONE;
          end else if (GAP == 0) begin
            // back-to-back repetitions: no detour through GAP
            w_bitcnt_nx = '0;
            w_repcnt_nx = r_repcnt + 8'd1;
          end else begin
            w_state_nx  = S_GAP;
            w_gapcnt_nx = '0;
          end
        end else begin
          w_bitcnt_nx = r_bitcnt + 16'd1;
        end
      end
      S_GAP: begin
        if (r_gapcnt == GAP_LAST) begin
          w_state_nx  = S_SEND;
          w_bitcnt_nx = '0;
          w_repcnt_nx = r_repcnt + 8'd1;
        end else begin
          w_gapcnt_nx = r_gapcnt + 16'd1;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // outputs are registered copies of what the next state will present
  always_comb begin
    w_idx      = IW'(BIT_LAST - w_bitcnt_nx);
    w_valid_nx = (w_state_nx == S_SEND);
    w_o_nx     = w_valid_nx & MSG_BITS[w_idx];
    w_busy_nx  = (w_state_nx != S_IDLE);
    w_done_nx  = (w_state_nx == S_DONE);
  end

endmodule

// File: tb/tb_param_string_serializer.sv
// Bench for param_string_serializer: reset vector table plus scoreboarded
// transmissions on four differently parameterised instances.
module tb_param_string_serializer;
  logic clk = 1'b0;
  logic rst;
  logic start   [4];
  logic O_w     [4];
  logic valid_w [4];
  logic busy_w  [4];
  logic done_w  [4];

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  int vcount = 0;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  param_string_serializer #(.MSG("AB"), .MSG_LEN(2), .REPEAT(1), .GAP(2)) u0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .O(O_w[0]), .valid(valid_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  param_string_serializer #(.MSG("AB"), .MSG_LEN(2), .REPEAT(3), .GAP(2)) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .O(O_w[1]), .valid(valid_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  param_string_serializer #(.MSG("AB"), .MSG_LEN(2), .REPEAT(259), .GAP(0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]),
    .O(O_w[2]), .valid(valid_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  param_string_serializer #(.MSG("AB"), .MSG_LEN(2), .REPEAT(0), .GAP(2)) u3 (
    .clk(clk), .rst(rst), .start(start[3]),
    .O(O_w[3]), .valid(valid_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  function automatic logic [3:0] act(input int i);
    return {O_w[i], valid_w[i], busy_w[i], done_w[i]};
  endfunction

  // expected {O,valid,busy,done} k cycles after the start cycle, from the timing rules
  function automatic logic [3:0] exp_at(input int k, input int r, input int g);
    logic [15:0] m = 16'h4142;
    int nb = 16;
    int t, p;
    if (k < 1) return 4'b0000;
    if (r == 0) return (k == 1) ? 4'b0011 : 4'b0000;
    t = r * nb + (r - 1) * g;
    if (k - 1 < t) begin
      p = (k - 1) % (nb + g);
      if (p < nb) return {m[4'(nb - 1 - p)], 3'b110};
      return 4'b0010;
    end
    if (k - 1 == t) return 4'b0011;
    return 4'b0000;
  endfunction

  task automatic chk(input int cyc_no);
    logic [3:0] e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow u%0d cycle %0d", sel, cyc_no);
    end else begin
      e = q.pop_front();
      if (act(sel) !== e) begin
        errors++;
        $display("FAIL seq u%0d cycle %0d got OVBD=%b want %b", sel, cyc_no, act(sel), e);
      end
    end
    if (valid_w[sel] === 1'b1) vcount++;
  endtask

  // one transmission: start at cycle 0, extra start window [sl,sh], optional rst at cycle ra
  task automatic run(input int s, input int r, input int g, input int n,
                     input int sl, input int sh, input int ra);
    sel = s;
    vcount = 0;
    for (int k = 0; k < n; k++)
      q.push_back((ra >= 0 && k > ra) ? 4'b0000 : exp_at(k, r, g));
    for (int k = 0; k < n; k++) begin
      start[s] = (k == 0) || (k >= sl && k <= sh);
      rst      = (k == ra);
      @(negedge clk);
      chk(k);
      @(posedge clk);
      #1;
    end
    start[s] = 1'b0;
    rst      = 1'b0;
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic [3:0] e;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 7; i++) tbl[i] = '{r: (i < 2), s: 1'b0, e: 4'b0000};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].r;
      for (int j = 0; j < 4; j++) start[j] = tbl[i].s;
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (act(j) !== tbl[i].e) begin
          errors++;
          $display("FAIL reset u%0d row %0d got OVBD=%b want %b", j, i, act(j), tbl[i].e);
        end
      end
      @(posedge clk);
      #1;
    end

    run(0, 1, 2, 20, -1, -1, -1);          // single message
    run(1, 3, 2, 56, 5, 9, -1);            // gaps, start re-asserted mid-SEND
    run(2, 259 % 256, 0, 52, -1, -1, -1);  // sized truncation, back-to-back
    checks++;
    if (vcount != 48) begin
      errors++;
      $display("FAIL trunc_valid_count got %0d want 48", vcount);
    end
    run(3, 0, 2, 4, -1, -1, -1);           // REPEAT=0
    run(1, 3, 2, 12, -1, -1, 7);           // reset in cycle 7 of SEND
    run(1, 3, 2, 56, -1, -1, -1);          // restart from first bit

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_string_serializer.md
# param_string_serializer

Serial stimulus source for the parameter-type round-trip designs. It drives the single-bit input of a passthrough stage, so a string parameter, a sized integer parameter and a derived localparam all affect observable, clocked behaviour. On each start request it shifts the characters of a string parameter out MSB-first, repeats the message a sized number of times with idle gaps between repetitions, then signals completion.

## Interface
Parameters:
- MSG, "A string.": string parameter; the message to transmit.
- MSG_LEN, 9: number of 8-bit characters in MSG; must be at least 1.
- [7:0] REPEAT, 3: number of message repetitions.
  - Declared sized: values above 255 truncate to 8 bits (e.g. 259 gives 3).
- GAP, 2: idle cycles between repetitions; 0 allowed.
- Localparam [15:0] NBITS = 8*MSG_LEN: bits per repetition; truncated to 16 bits.

Ports:
- clk  input  1  sole clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a transmission; sampled only in IDLE.
- O  output  1  serial data bit, registered.
- valid  output  1  O carries a message bit this cycle.
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle pulse when the transmission completes.

## Operation
- States: IDLE, SEND, GAP, DONE.
- Counters:
  - bit counter, 0..NBITS-1;
  - gap counter, 0..GAP-1;
  - repetition counter, 8 bits, 0..REPEAT-1.
- IDLE:
  - start=1 and REPEAT!=0: go to SEND; clear all counters.
  - start=1 and REPEAT==0: go straight to DONE; no bits are sent.
  - start=0: remain in IDLE.
- SEND:
  - O = MSG[NBITS-1-bitcnt], so the leftmost character goes first, each character MSB-first.
  - valid=1.
  - bitcnt increments each cycle.
  - On the last bit (bitcnt==NBITS-1):
    - if this is the final repetition (repcnt==REPEAT-1), go to DONE;
    - else if GAP==0, stay in SEND with bitcnt=0 and repcnt+1 (back-to-back repetitions);
    - else go to GAP.
- GAP:
  - O=0, valid=0.
  - Lasts exactly GAP cycles, then returns to SEND with bitcnt=0 and repcnt+1.
- DONE:
  - done=1, O=0, valid=0, busy=1, for one cycle only.
  - Then returns to IDLE.
- start is ignored in every state except IDLE; it is not queued.
- start held high continuously: a new transmission begins in the first IDLE cycle after DONE.
- All outputs are registered, decoded from the next state.

## Timing
- Reset values: O=0, valid=0, busy=0, done=0; state IDLE; all counters 0.
- Reset mid-operation: on the cycle after rst is sampled high, all outputs are 0 and the state is IDLE. Reset takes priority over start.
- Latency: start sampled at edge N gives the first message bit with valid=1 in cycle N+1.
- Total busy cycles for REPEAT=R≥1: R*NBITS + (R-1)*GAP + 1, where the +1 is the DONE cycle.
- REPEAT==0: busy for one cycle (DONE), in cycle N+1; done=1 in that same cycle.
- Earliest restart: the next start is accepted at the edge that ends the first IDLE cycle after DONE.

## Test plan
- Reset, then check outputs:
  - stimulus: rst=1 for 2 cycles, then release with start=0 for 5 cycles;
  - required: O=valid=busy=done=0 throughout.
- Single message:
  - stimulus: MSG="AB", MSG_LEN=2, REPEAT=1; start pulsed at cycle 0;
  - required: cycles 1–16 carry O=0100000101000010 with valid=1;
  - required: done=1 at cycle 17; busy falls at cycle 18.
- Repeats with gap:
  - stimulus: MSG="AB", REPEAT=3, GAP=2;
  - required: valid high in cycles 1–16, 19–34 and 37–52;
  - required: valid=0, O=0 in cycles 17–18 and 35–36;
  - required: done at cycle 53.
- Sized truncation:
  - stimulus: REPEAT=259, GAP=0;
  - required: exactly 3 back-to-back repetitions (48 valid cycles), then done.
- REPEAT=0:
  - stimulus: start pulse;
  - required: done=1 at cycle 1; valid never high.
- Protocol corner cases:
  - stimulus: start re-asserted mid-SEND;
  - required: ignored; the output sequence is unchanged.
  - stimulus: rst asserted in cycle 7 of SEND;
  - required: all outputs 0 from cycle 8 onward.
  - stimulus: a new start after reset;
  - required: transmission restarts from the first bit.
